vxe_cu_cmd_encoder: RTL

VXE_CU_CMD_ENCODER -- requirements
Module: vxe_cu_cmd_encoder

---
 rtl/vxe_cu_cmd_encoder_pkg.sv | 42 ++++
 rtl/vxe_cu_cmd_enc_fifo.sv | 62 ++++++
 rtl/vxe_cu_cmd_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vxe_cu_cmd_encoder_pkg.sv
// Shared command definitions for the VXE compute-unit command encoder:
// opcodes, RELU function codes, per-opcode legal payload widths.
package vxe_cu_cmd_encoder_pkg;

    localparam int CU_CMD_W    = 64;
    localparam int CU_CMD_PL_W = 38;

    typedef enum logic [4:0] {
        CU_CMD_NOP    = 5'd0,
        CU_CMD_SETACC = 5'd1,
        CU_CMD_SETVL  = 5'd2,
        CU_CMD_SETRS  = 5'd3,
        CU_CMD_SETRT  = 5'd4,
        CU_CMD_SETRD  = 5'd5,
        CU_CMD_SETEN  = 5'd6,
        CU_CMD_SYNC   = 5'd7,
        CU_CMD_RELU   = 5'd8,
        CU_CMD_PROD   = 5'd9,
        CU_CMD_STORE  = 5'd10
    } cu_cmd_op_e;

    localparam logic [7:0] CU_CMD_RELU_RELU  = 8'h00;
    localparam logic [7:0] CU_CMD_RELU_LRELU = 8'h01;

    localparam logic [5:0] CU_CMD_PL_W_SETACC = 6'd32;
    localparam logic [5:0] CU_CMD_PL_W_SETVL  = 6'd20;
    localparam logic [5:0] CU_CMD_PL_W_SETRX  = 6'd38;
    localparam logic [5:0] CU_CMD_PL_W_SETEN  = 6'd1;
    localparam logic [5:0] CU_CMD_PL_W_SYNC   = 6'd2;
    localparam logic [5:0] CU_CMD_PL_W_RELU   = 6'd7;
    localparam logic [5:0] CU_CMD_PL_W_NONE   = 6'd0;

    // Mask with the low 'width' payload bits set.
    function automatic logic [CU_CMD_PL_W-1:0] cu_cmd_pl_mask(input logic [5:0] width);
        logic [CU_CMD_PL_W-1:0] mask;
        for (int i = 0; i < CU_CMD_PL_W; i++) begin
            mask[i] = (6'(i) < width);
        end
        return mask;
    endfunction

endpackage

// File: rtl/vxe_cu_cmd_enc_fifo.sv
// Command-word queue for the encoder: power-of-two depth, wrapping pointers,
// zero head word while empty. Push is refused when full even if popping.
module vxe_cu_cmd_enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      fill_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (fill_r == (AW+1)'(DEPTH));
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && (fill_r != '0);

    // Storage array; contents are meaningless while fill_r says empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            fill_r   <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   fill_r <= fill_r + (AW+1)'(1);
                2'b01:   fill_r <= fill_r - (AW+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    assign fill       = fill_r;
    assign head_valid = (fill_r != '0);
    assign head_data  = (fill_r != '0) ? mem_r[rd_ptr_r] : '0;

endmodule

// File: rtl/vxe_cu_cmd_encoder.sv
// Encodes CU requests into 64-bit command words and queues them.
// Define VXE_CU_CMD_ENC_CHECK_EN to drop illegal requests and count drops.
module vxe_cu_cmd_encoder
    import vxe_cu_cmd_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int TOTAL_THR_NR = 8
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [4:0]                    i_op,
    input  logic [7:0]                    i_fun,
    input  logic [37:0]                   i_pl,
    output logic                          o_cmd_valid,
    input  logic                          i_cmd_ready,
    output logic [63:0]                   o_cmd,
    output logic                          o_enc_err,
    output logic [7:0]                    o_err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TOTAL_THR_NR < 1 || TOTAL_THR_NR > 256) begin : g_bad_param
        $error("vxe_cu_cmd_encoder: illegal parameter set");
    end

    logic [5:0]             pl_w_s;
    logic                   fun_zero_s;
    logic [CU_CMD_PL_W-1:0] pl_mask_s;
    logic [CU_CMD_W-1:0]    cmd_s;
    logic                   accept_s;
    logic                   drop_s;
    logic                   push_s;
    logic                   full_s;

    // Per-opcode payload width and whether the function field is forced to zero.
    always_comb begin
        pl_w_s     = CU_CMD_PL_W_NONE;
        fun_zero_s = 1'b0;
        case (i_op)
            CU_CMD_NOP, CU_CMD_PROD, CU_CMD_STORE: fun_zero_s = 1'b1;
            CU_CMD_SYNC: begin
                pl_w_s     = CU_CMD_PL_W_SYNC;
                fun_zero_s = 1'b1;
            end
            CU_CMD_SETACC: pl_w_s = CU_CMD_PL_W_SETACC;
            CU_CMD_SETVL:  pl_w_s = CU_CMD_PL_W_SETVL;
            CU_CMD_SETRS, CU_CMD_SETRT, CU_CMD_SETRD: pl_w_s = CU_CMD_PL_W_SETRX;
            CU_CMD_SETEN:  pl_w_s = CU_CMD_PL_W_SETEN;
            CU_CMD_RELU:   pl_w_s = CU_CMD_PL_W_RELU;
            default:       pl_w_s = CU_CMD_PL_W_NONE;
        endcase
    end

    assign pl_mask_s = cu_cmd_pl_mask(pl_w_s);
    assign cmd_s     = {i_op, (fun_zero_s ? 8'h00 : i_fun), 13'h0000, (i_pl & pl_mask_s)};
    assign accept_s  = i_valid && !full_s;
    assign push_s    = accept_s && !drop_s;
    assign o_ready   = !full_s;

`ifdef VXE_CU_CMD_ENC_CHECK_EN
    localparam logic [8:0] THR_LIM = 9'(TOTAL_THR_NR);

    logic known_s;
    logic thr_op_s;
    logic relu_op_s;
    logic illegal_s;
    logic enc_err_r;
    logic [7:0] err_cnt_r;

    // Classify the opcode for the legality checks.
    always_comb begin
        known_s   = 1'b1;
        thr_op_s  = 1'b0;
        relu_op_s = 1'b0;
        case (i_op)
            CU_CMD_NOP, CU_CMD_PROD, CU_CMD_STORE, CU_CMD_SYNC: known_s = 1'b1;
            CU_CMD_SETACC, CU_CMD_SETVL, CU_CMD_SETRS,
            CU_CMD_SETRT, CU_CMD_SETRD, CU_CMD_SETEN: thr_op_s = 1'b1;
            CU_CMD_RELU: relu_op_s = 1'b1;
            default:     known_s = 1'b0;
        endcase
    end

    assign illegal_s = !known_s
                     || (thr_op_s && ({1'b0, i_fun} >= THR_LIM))
                     || (relu_op_s && (i_fun != CU_CMD_RELU_RELU) && (i_fun != CU_CMD_RELU_LRELU))
                     || ((i_pl & ~pl_mask_s) != '0)
                     || (fun_zero_s && (i_fun != 8'h00));
    assign drop_s = accept_s && illegal_s;

    // One-cycle drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            enc_err_r <= 1'b0;
            err_cnt_r <= 8'h00;
        end else begin
            enc_err_r <= drop_s;
            if (drop_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign o_enc_err = enc_err_r;
    assign o_err_cnt = err_cnt_r;
`else
    assign drop_s    = 1'b0;
    assign o_enc_err = 1'b0;
    assign o_err_cnt = 8'h00;
`endif

    vxe_cu_cmd_enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CU_CMD_W)
    ) u_fifo (
        .clk        (clk),
        .nrst       (nrst),
        .push       (push_s),
        .push_data  (cmd_s),
        .pop        (i_cmd_ready),
        .fill       (o_fill),
        .full       (full_s),
        .head_valid (o_cmd_valid),
        .head_data  (o_cmd)
    );

endmodule
